// File: rtl/memory_bus_responder.sv
// memory_bus_responder: word-addressed 32-bit memory on a shared tri-state bus.
// Reads complete after READ_LATENCY cycles and are then held until the next
// accepted command. The bus is driven only while the held data is valid and
// the control unit grants the output enable.
module memory_bus_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_out,
  inout  tri   [31:0]           bus,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  wr_ack,
  output logic                  cmd_err
);

  localparam int          DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  LAT_INIT = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    DATA_VALID = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q, addr_q_next;
  logic [3:0]            count, count_next;
  logic [31:0]           data_q;
  logic                  do_write, do_load, ack_next, err_next;

  // Storage is deliberately left out of reset so it maps onto block RAM.
  logic [31:0] mem [0:DEPTH-1];

  // Next-state and command decode; reads and writes are only accepted in IDLE
  // and DATA_VALID, anything arriving while a read is pending is an error.
  always_comb begin
    state_next  = state;
    addr_q_next = addr_q;
    count_next  = count;
    do_write    = 1'b0;
    do_load     = 1'b0;
    ack_next    = 1'b0;
    err_next    = 1'b0;
    case (state)
      IDLE, DATA_VALID: begin
        if (mem_read && mem_write) begin
          err_next = 1'b1;
        end else if (mem_read) begin
          addr_q_next = addr;
          count_next  = LAT_INIT;
          state_next  = READ_WAIT;
        end else if (mem_write) begin
          do_write   = 1'b1;
          ack_next   = 1'b1;
          state_next = IDLE;
        end
      end
      READ_WAIT: begin
        err_next = mem_read | mem_write;
        if (count == 4'd0) begin
          do_load    = 1'b1;
          state_next = DATA_VALID;
        end else begin
          count_next = count - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, captured address, latency counter, read data and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      count     <= 4'd0;
      data_q    <= 32'd0;
      mem_ready <= 1'b0;
      mem_busy  <= 1'b0;
      wr_ack    <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_next;
      addr_q    <= addr_q_next;
      count     <= count_next;
      if (do_load) begin
        data_q <= mem[addr_q];
      end
      mem_ready <= (state_next == DATA_VALID);
      mem_busy  <= (state_next == READ_WAIT);
      wr_ack    <= ack_next;
      cmd_err   <= err_next;
    end
  end

  // Memory write port; write data is whatever another unit drives on the bus.
  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      mem[addr] <= bus;
    end
  end

  // Bus drive follows the grant combinationally, only while data is held.
  assign bus = ((state == DATA_VALID) && mem_out) ? data_q : 32'bz;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Testbench for memory_bus_responder: directed scenarios followed by random
// traffic, all checked against a timestamp-based reference model. The bus has
// a pull-up, so a released bus reads as all ones.
module tb_memory_bus_responder;

  localparam int          AW       = 10;
  localparam int          LAT      = 2;
  localparam logic [31:0] BUS_IDLE = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr = '0;
  logic          mem_read = 1'b0, mem_write = 1'b0, mem_out = 1'b0;
  logic          mem_ready, mem_busy, wr_ack, cmd_err;
  logic          tb_drv = 1'b0;
  logic [31:0]   tb_data = 32'd0;
  tri1  [31:0]   bus;

  assign bus = tb_drv ? tb_data : 32'bz;

  memory_bus_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .addr(addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_out(mem_out), .bus(bus),
    .mem_ready(mem_ready), .mem_busy(mem_busy), .wr_ack(wr_ack),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // Reference model: memory image plus the timing of the pending read.
  logic [31:0] m_mem   [1024];
  bit          m_known [1024];
  int          cyc = 0;
  bit          pend = 0;
  int          done_cycle = 0;
  int          rd_addr = 0;
  bit          have_data = 0;
  bit          data_known = 0;
  logic [31:0] data_held = 32'd0;
  bit          exp_ack = 0;
  bit          exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if (w == BUS_IDLE) w = 32'h0F0F_0F0F;
    return w;
  endfunction

  task automatic model_reset();
    pend = 0; have_data = 0; data_known = 0; exp_ack = 0; exp_err = 0;
  endtask

  // What the memory should do at one rising edge with the given inputs.
  task automatic model_edge(input bit r, input bit w, input int a, input logic [31:0] d);
    cyc++;
    exp_ack = 0;
    exp_err = 0;
    if (reset) begin
      model_reset();
      return;
    end
    if (pend) begin
      exp_err = r | w;
      if (cyc == done_cycle) begin
        pend       = 0;
        have_data  = 1;
        data_known = m_known[rd_addr];
        data_held  = m_mem[rd_addr];
      end
    end else if (r && w) begin
      exp_err = 1;
    end else if (r) begin
      pend       = 1;
      done_cycle = cyc + LAT;
      rd_addr    = a;
      have_data  = 0;
    end else if (w) begin
      m_mem[a]   = d;
      m_known[a] = 1;
      exp_ack    = 1;
      have_data  = 0;
    end
  endtask

  task automatic check_bus();
    if (tb_drv) return;
    if (have_data && mem_out) begin
      if (data_known) chk("bus_data", bus, data_held);
    end else begin
      chk("bus_idle", bus, BUS_IDLE);
    end
  endtask

  task automatic check_outputs();
    chk("mem_busy",  {31'd0, mem_busy},  {31'd0, pend});
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, have_data});
    chk("wr_ack",    {31'd0, wr_ack},    {31'd0, exp_ack});
    chk("cmd_err",   {31'd0, cmd_err},   {31'd0, exp_err});
    check_bus();
  endtask

  // One bus cycle: inputs set after the falling edge, checked 1ns after the rising edge.
  task automatic step(input bit r, input bit w, input bit o, input int a, input logic [31:0] d);
    mem_read = r; mem_write = w; mem_out = o; addr = AW'(a);
    tb_data = d; tb_drv = w;
    @(posedge clk);
    model_edge(r, w, a, d);
    #1;
    txn++;
    $display("txn %0d rst=%b r=%b w=%b o=%b a=%h d=%h busy=%b rdy=%b ack=%b err=%b",
             txn, reset, r, w, o, addr, d, mem_busy, mem_ready, wr_ack, cmd_err);
    check_outputs();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic async_reset(input int hold);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    for (int i = 0; i < hold; i++) step(0, 0, mem_out, 0, 32'd0);
    reset = 1'b0;
  endtask

  task automatic do_read(input int a, input bit o);
    step(1, 0, 0, a, 32'd0);
    for (int i = 0; i < LAT; i++) step(0, 0, o, a, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      m_mem[i] = 32'd0;
      m_known[i] = 0;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'd0);
    reset = 1'b0;

    // Write then read at address 5.
    step(0, 1, 0, 5, 32'hDEAD_BEEF);
    do_read(5, 0);
    step(0, 0, 1, 5, 32'd0);
    chk("rd5_drive", bus, 32'hDEAD_BEEF);
    step(0, 0, 0, 5, 32'd0);
    chk("rd5_release", bus, BUS_IDLE);

    // Reset mid-cycle while driving the bus, then idle for 5 cycles.
    step(0, 0, 1, 5, 32'd0);
    async_reset(2);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 32'd0);

    // Address capture and wrap: addr moves to 0 during the wait.
    step(0, 1, 0, 10'h3FF, 32'h1);
    step(0, 1, 0, 0, 32'h2);
    step(1, 0, 0, 10'h3FF, 32'd0);
    for (int i = 0; i < LAT; i++) step(0, 0, 0, 0, 32'd0);
    step(0, 0, 1, 0, 32'd0);
    chk("wrap_3ff", bus, 32'h1);
    do_read(0, 1);
    chk("wrap_000", bus, 32'h2);

    // Illegal commands: both high while holding data, then a write mid-read.
    step(1, 1, 0, 5, 32'h1234_5678);
    step(0, 0, 0, 5, 32'd0);
    do_read(5, 1);
    chk("err_nowrite", bus, 32'hDEAD_BEEF);
    step(1, 0, 0, 0, 32'd0);
    step(0, 1, 0, 0, 32'hAAAA_5555);
    for (int i = 1; i < LAT; i++) step(0, 0, 0, 0, 32'd0);
    step(0, 0, 1, 0, 32'd0);
    chk("err_midread", bus, 32'h2);

    // Reset one cycle into a read: no completion may follow.
    step(1, 0, 0, 5, 32'd0);
    step(0, 0, 1, 5, 32'd0);
    async_reset(1);
    for (int i = 0; i < LAT + 4; i++) step(0, 0, 1, 5, 32'd0);

    // Hold data for 10 cycles with mem_out toggling mid-cycle, then replace.
    do_read(5, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, i[0], 5, 32'd0);
      #1 mem_out = ~mem_out;
      #1 check_bus();
    end
    step(0, 1, 0, 7, 32'h0BAD_F00D);
    step(0, 0, 1, 7, 32'd0);
    chk("replace_idle", bus, BUS_IDLE);

    // Random traffic over a small address window.
    for (int i = 0; i < 600; i++) begin
      bit r, w, o;
      int a;
      r = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 4) == 0);
      o = w ? 1'b0 : 1'($urandom_range(0, 1));
      a = $urandom_range(0, 31);
      step(r, w, o, a, rand_word());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_bus_responder.md
# memory_bus_responder

Word-addressed 32-bit memory that answers the processor control unit over the shared 32-bit tri-state data bus. The address comes from the memory address register's output. Writes take data from the bus. Reads complete after a fixed, parameterised latency and drive the bus only while the control unit grants the output enable. Sits between the memory address register, the control sequencer and the shared bus.

## Interface
- ADDR_WIDTH, 10: address width; memory depth is 2**ADDR_WIDTH words of 32 bits.
- READ_LATENCY, 2: cycles from read acceptance to data valid; legal range 1..15.

- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- addr  input  ADDR_WIDTH  word address, driven from the memory address register output.
- mem_read  input  1  read request from control, level-sampled.
- mem_write  input  1  write request from control, level-sampled; data taken from bus.
- mem_out  input  1  bus drive grant from control.
- bus  inout  32  shared tri-state data bus.
- mem_ready  output  1  registered; high while read data is held valid.
- mem_busy  output  1  registered; high while a read is in progress.
- wr_ack  output  1  registered; one-cycle pulse after a write is committed.
- cmd_err  output  1  registered; one-cycle pulse on an illegal command.

## Operation
- Storage: 2**ADDR_WIDTH x 32 array. It is not cleared by reset, and its contents after power-up are undefined. Internal registers: addr_q, data_q (32), latency counter (4 bits), FSM state.
- FSM states:
  - IDLE: no valid data.
  - READ_WAIT: counting down the read latency.
  - DATA_VALID: data_q holds read result.
- Accepting states are IDLE and DATA_VALID. In an accepting state, at each clock edge:
  - mem_read=1, mem_write=0: addr_q<=addr, counter<=READ_LATENCY-1, go to READ_WAIT.
  - mem_write=1, mem_read=0: mem[addr]<=bus, wr_ack pulses, go to IDLE. Previously held read data is discarded.
  - Both high: neither is executed; cmd_err pulses; state unchanged.
  - Neither high: state unchanged. DATA_VALID holds data_q indefinitely.
- READ_WAIT:
  - If counter==0: data_q<=mem[addr_q], go to DATA_VALID.
  - Otherwise the counter decrements.
  - Any mem_read or mem_write seen in READ_WAIT is ignored and pulses cmd_err.
  - Changes on addr during READ_WAIT have no effect.
- Bus drive (combinational): bus = data_q when state==DATA_VALID and mem_out=1; otherwise all bits 'z. mem_out in any other state is legal, leaves the bus at 'z, and is not an error.
- Write data is the value on bus at the accepting edge. The control unit guarantees another unit drives the bus in that cycle.
- Write followed by read to the same address returns the newly written word.
- Address wrap is natural: addr is exactly ADDR_WIDTH bits and there is no out-of-range case.

## Timing
- Reset (async, immediate): state=IDLE, mem_ready=0, mem_busy=0, wr_ack=0, cmd_err=0, data_q=0, addr_q=0, counter=0. bus releases to 'z without waiting for a clock edge. Reset during READ_WAIT aborts the read with no later completion.
- Read latency: read accepted at edge T0. mem_busy is high from T0 to T0+READ_LATENCY. mem_ready rises after edge T0+READ_LATENCY.
  - READ_LATENCY=1: mem_ready rises one cycle after acceptance.
  - READ_LATENCY=2 (default): mem_ready rises two cycles after acceptance.
- mem_ready and mem_busy are never high together. mem_ready falls on the edge that accepts the next command.
- Write: committed at the accepting edge. wr_ack is high for exactly the following cycle. A back-to-back read on the next edge is legal.
- Bus drive follows mem_out combinationally within the same cycle. Drive stops in the cycle after the edge that leaves DATA_VALID.
- cmd_err is high for exactly one cycle per offending edge. Consecutive offending edges give consecutive pulses.

## Test plan
- Reset state: assert reset mid-cycle with mem_out=1 -> all outputs 0 and bus='z immediately. Release reset, hold idle 5 cycles -> outputs unchanged.
- Write then read, READ_LATENCY=2: drive bus=32'hDEADBEEF, addr=10'h05, mem_write for 1 cycle -> wr_ack pulses next cycle. Then mem_read with addr=5 -> mem_busy high 2 cycles, then mem_ready=1. With mem_out=1 -> bus=32'hDEADBEEF; with mem_out=0 -> bus='z.
- Address capture and wrap: write 32'h1 to addr 10'h3FF and 32'h2 to addr 0. Read 10'h3FF, and change addr to 0 during READ_WAIT -> returns 32'h1.
- Illegal commands: mem_read and mem_write both high in IDLE -> cmd_err single pulse, memory unchanged. mem_write during READ_WAIT -> cmd_err pulse, the read still completes with the correct data.
- Reset mid-read: mem_read accepted, reset asserted after 1 cycle -> mem_busy=0 and no mem_ready ever rises until a new read is accepted.
- Hold and replace: stay in DATA_VALID for 10 cycles toggling mem_out -> data stable and bus drive follows mem_out. A new mem_write then drops mem_ready next cycle and bus='z.
